// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: per-channel rising/falling edge
// detection, pending-event latching with overflow tracking, and a
// round-robin arbiter feeding a single registered valid/ready event slot.
module edge_event_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   data_in,
  input  logic [N-1:0]   rise_en,
  input  logic [N-1:0]   fall_en,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic           evt_rise,
  output logic [N-1:0]   overflow,
  input  logic [N-1:0]   clr_ovf
);

  logic [N-1:0]   data_d;
  logic [N-1:0]   pending;
  logic [N-1:0]   pend_rise;
  logic [IDW-1:0] rr_ptr;

  logic [N-1:0]   rise_v;
  logic [N-1:0]   fall_v;
  logic [N-1:0]   edge_v;
  logic           slot_load;

  logic           any_pend;
  logic           hi_found;
  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] lo_idx;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_rise;
  logic [N-1:0]   gnt_oh;
  logic [IDW-1:0] ptr_nx;

  logic [N-1:0]   pend_nx;
  logic [N-1:0]   rise_nx;
  logic [N-1:0]   ovf_nx;

  // Qualified edge detection against the previous-cycle sample.
  always_comb begin
    rise_v    = data_in & ~data_d & rise_en;
    fall_v    = ~data_in & data_d & fall_en;
    edge_v    = rise_v | fall_v;
    slot_load = ~evt_valid | evt_ready;
  end

  // Round-robin pick: lowest pending index at or above rr_ptr, else the
  // lowest pending index overall (wrap). Grant only when the slot can load.
  always_comb begin
    any_pend = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    gnt_oh   = '0;
    gnt_rise = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_pend && pending[i]) begin
        any_pend = 1'b1;
        lo_idx   = IDW'(i);
      end
      if (!hi_found && pending[i] && (i >= 32'(rr_ptr))) begin
        hi_found = 1'b1;
        hi_idx   = IDW'(i);
      end
    end
    gnt_idx = hi_found ? hi_idx : lo_idx;
    for (int unsigned i = 0; i < N; i++) begin
      if (slot_load && any_pend && (i == 32'(gnt_idx))) begin
        gnt_oh[i] = 1'b1;
        gnt_rise  = pend_rise[i];
      end
    end
    ptr_nx = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Pending/overflow update: a granted channel may re-arm with a new edge;
  // an edge on a pending, non-granted channel is dropped and flagged.
  always_comb begin
    pend_nx = pending & ~gnt_oh;
    rise_nx = pend_rise;
    ovf_nx  = overflow & ~clr_ovf;
    for (int unsigned i = 0; i < N; i++) begin
      if (edge_v[i]) begin
        if (pending[i] && !gnt_oh[i]) begin
          ovf_nx[i] = 1'b1;
        end else begin
          pend_nx[i] = 1'b1;
          rise_nx[i] = rise_v[i];
        end
      end
    end
  end

  // State registers and the output event slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_d    <= '0;
      pending   <= '0;
      pend_rise <= '0;
      rr_ptr    <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_rise  <= 1'b0;
      overflow  <= '0;
    end else begin
      data_d    <= data_in;
      pending   <= pend_nx;
      pend_rise <= rise_nx;
      overflow  <= ovf_nx;
      if (slot_load) begin
        if (any_pend) begin
          evt_valid <= 1'b1;
          evt_id    <= gnt_idx;
          evt_rise  <= gnt_rise;
          rr_ptr    <= ptr_nx;
        end else begin
          evt_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (N=4, IDW=2).
module tb_edge_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] data_in;
  logic [3:0] rise_en;
  logic [3:0] fall_en;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic       evt_rise;
  logic [3:0] overflow;
  logic [3:0] clr_ovf;

  int unsigned checks;
  int unsigned failures;

  edge_event_arbiter #(.N(4), .IDW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .rise_en  (rise_en),
    .fall_en  (fall_en),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .evt_rise (evt_rise),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [1:0] id, input logic r);
    chk({tag, ".valid"}, 32'(evt_valid), 32'(v));
    if (v) begin
      chk({tag, ".id"},   32'(evt_id),   32'(id));
      chk({tag, ".rise"}, 32'(evt_rise), 32'(r));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    data_in   = 4'b0000;
    rise_en   = 4'hF;
    fall_en   = 4'hF;
    evt_ready = 1'b1;
    clr_ovf   = 4'b0000;
    #2;

    // Reset and startup
    step(); step();
    chk("rst.valid", 32'(evt_valid), 32'd0);
    chk("rst.id",    32'(evt_id),    32'd0);
    chk("rst.rise",  32'(evt_rise),  32'd0);
    chk("rst.ovf",   32'(overflow),  32'd0);
    rst_n = 1'b1;
    step();
    data_in = 4'b0100;
    step();
    chk_slot("lat.t0", 1'b0, 2'd0, 1'b0);
    step();
    chk_slot("lat.t1", 1'b1, 2'd2, 1'b1);
    step();
    chk_slot("lat.t2", 1'b0, 2'd0, 1'b0);

    // Re-reset to bring rr_ptr back to 0, then simultaneous edges
    data_in = 4'b0000;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    data_in = 4'b1011;
    step();
    step(); chk_slot("sim.e0", 1'b1, 2'd0, 1'b1);
    step(); chk_slot("sim.e1", 1'b1, 2'd1, 1'b1);
    step(); chk_slot("sim.e3", 1'b1, 2'd3, 1'b1);
    step(); chk_slot("sim.idle", 1'b0, 2'd0, 1'b0);
    // ch1 falls -> ptr moves to 2; then ch0 fall and ch2 rise together
    data_in = 4'b1001;
    step();
    step(); chk_slot("rr.e1", 1'b1, 2'd1, 1'b0);
    data_in = 4'b1100;
    step(); chk_slot("rr.gap", 1'b0, 2'd0, 1'b0);
    step(); chk_slot("rr.e2", 1'b1, 2'd2, 1'b1);
    step(); chk_slot("rr.e0", 1'b1, 2'd0, 1'b0);
    step(); chk_slot("rr.idle", 1'b0, 2'd0, 1'b0);

    // Backpressure: presented event held while another pends
    evt_ready = 1'b0;
    data_in = 4'b1110;
    step();
    step(); chk_slot("bp.load", 1'b1, 2'd1, 1'b1);
    data_in = 4'b1010;
    step(); chk_slot("bp.hold0", 1'b1, 2'd1, 1'b1);
    step(); chk_slot("bp.hold1", 1'b1, 2'd1, 1'b1);
    evt_ready = 1'b1;
    step(); chk_slot("bp.next", 1'b1, 2'd2, 1'b0);
    step(); chk_slot("bp.idle", 1'b0, 2'd0, 1'b0);

    // Overflow on ch3 while its first event is held
    evt_ready = 1'b0;
    data_in = 4'b0010;
    step();
    step(); chk_slot("ovf.slot", 1'b1, 2'd3, 1'b0);
    data_in = 4'b1010;
    step(); chk("ovf.none", 32'(overflow), 32'h0);
    data_in = 4'b0010;
    step(); chk("ovf.set", 32'(overflow), 32'h8);
    chk_slot("ovf.held", 1'b1, 2'd3, 1'b0);
    clr_ovf = 4'b1000;
    step();
    clr_ovf = 4'b0000;
    chk("ovf.clr", 32'(overflow), 32'h0);
    data_in = 4'b1010;
    clr_ovf = 4'b1000;
    step();
    clr_ovf = 4'b0000;
    chk("ovf.setwins", 32'(overflow), 32'h8);
    clr_ovf = 4'b1000;
    step();
    clr_ovf = 4'b0000;
    chk("ovf.clr2", 32'(overflow), 32'h0);
    // Grant and new edge in the same cycle: re-arms with new type
    evt_ready = 1'b1;
    data_in = 4'b0010;
    step(); chk_slot("rearm.e0", 1'b1, 2'd3, 1'b1);
    chk("rearm.ovf", 32'(overflow), 32'h0);
    step(); chk_slot("rearm.e1", 1'b1, 2'd3, 1'b0);
    step(); chk_slot("rearm.idle", 1'b0, 2'd0, 1'b0);

    // Enable masking on ch0: only the falling edge is reported
    rise_en = 4'h0;
    fall_en = 4'h1;
    data_in = 4'b0011;
    step();
    step(); chk_slot("mask.rise", 1'b0, 2'd0, 1'b0);
    data_in = 4'b0010;
    step();
    fall_en = 4'h0;
    step(); chk_slot("mask.fall", 1'b1, 2'd0, 1'b0);
    step(); chk_slot("mask.idle", 1'b0, 2'd0, 1'b0);
    chk("mask.ovf", 32'(overflow), 32'h0);

    // Reset mid-operation with pending and presented events
    rise_en = 4'hF;
    fall_en = 4'hF;
    evt_ready = 1'b0;
    data_in = 4'b1101;
    step();
    step(); chk_slot("mid.slot", 1'b1, 2'd1, 1'b0);
    data_in = 4'b1100;
    step(); chk("mid.ovf", 32'(overflow), 32'h1);
    rst_n = 1'b0;
    data_in = 4'b0000;
    step();
    chk("mid.rst.valid", 32'(evt_valid), 32'd0);
    chk("mid.rst.ovf",   32'(overflow),  32'd0);
    chk("mid.rst.id",    32'(evt_id),    32'd0);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      chk("mid.quiet", 32'(evt_valid), 32'd0);
    end
    data_in = 4'b0001;
    step(); chk_slot("mid.new0", 1'b0, 2'd0, 1'b0);
    step(); chk_slot("mid.new1", 1'b1, 2'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
